hazard_stall_ctrl: RTL



---
 rtl/hazard_stall_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// RAW-hazard scoreboard and stall/halt sequencer for the mips_16 pipeline.
// Latency: hazard and enables are same-cycle combinational; state, halt_ack, stall_cnt registered.
// Backpressure: a hazard drops fetch/decode enables (bubble into EX); halt drains EX/MEM/WB first.
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_write_en,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  halt_req,
    input  logic                  stall_cnt_clr,
    output logic                  instruction_fetch_en,
    output logic                  instruction_decode_en,
    output logic                  halt_ack,
    output logic                  hazard,
    output logic                  sb_busy,
    output logic [1:0]            ctrl_state,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALTING = 2'd1,
        HALTED  = 2'd2
    } state_t;

    typedef struct packed {
        logic                  vld;
        logic [REG_ADDR_W-1:0] dest;
    } sb_entry_t;

    state_t           state_q;
    sb_entry_t [2:0]  sb_q;
    logic             halt_ack_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             src1_hit;
    logic             src2_hit;
    logic             run;

    // WB (sb_q[2]) is still a hazard: the regfile write lands after the ID read.
    always_comb begin
        src1_hit = 1'b0;
        src2_hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (sb_q[i].vld && (sb_q[i].dest == id_src1)) src1_hit = 1'b1;
            if (sb_q[i].vld && (sb_q[i].dest == id_src2)) src2_hit = 1'b1;
        end
    end

    assign hazard  = id_valid & (((id_src1 != '0) & src1_hit) | ((id_src2 != '0) & src2_hit));
    assign sb_busy = sb_q[0].vld | sb_q[1].vld | sb_q[2].vld;
    assign run     = (state_q == RUN);

    // Enables are gated by rst_n so the pipeline is frozen for the whole reset pulse.
    assign instruction_fetch_en  = rst_n & run & ~hazard;
    assign instruction_decode_en = rst_n & run & ~hazard;
    assign halt_ack              = halt_ack_q;
    assign ctrl_state            = state_q;
    assign stall_cnt             = stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            sb_q        <= '0;
            halt_ack_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            sb_q[0] <= '{vld:  instruction_decode_en & id_valid & id_write_en & (id_dest != '0),
                         dest: id_dest};
            sb_q[1] <= sb_q[0];
            sb_q[2] <= sb_q[1];

            if (stall_cnt_clr)
                stall_cnt_q <= '0;
            else if (run && hazard && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);

            case (state_q)
                RUN: begin
                    halt_ack_q <= 1'b0;
                    if (halt_req) state_q <= HALTING;
                end
                HALTING: begin
                    if (!halt_req) begin
                        state_q    <= RUN;
                        halt_ack_q <= 1'b0;
                    end else if (!sb_busy) begin
                        state_q    <= HALTED;
                        halt_ack_q <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!halt_req) begin
                        state_q    <= RUN;
                        halt_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    halt_ack_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
